// File: rtl/imem_loader.sv
// Boot-time loader: assembles big-endian 16-bit words from a byte stream and writes them
// into instruction memory. The image is length-prefixed and checksum-terminated.
module imem_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          reload,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [15:0]   im_data,
  output logic          core_run,
  output logic          load_err
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_LOAD = 3'd1,
    S_CSUM = 3'd2,
    S_RUN  = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   acc_q, acc_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          ready_q, run_q, err_q;

  logic [15:0]   word_s;
  logic          accept_s;
  logic [CW-1:0] cnt_inc_s;

  assign word_s    = {hi_q, in_data};
  assign accept_s  = in_valid & ready_q;
  assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};

  // Next-state, byte assembly and memory-write generation
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (reload) begin
      // Reload wins over a byte accepted in the same cycle
      state_d = S_HDR;
      phase_d = 1'b0;
      cnt_d   = {CW{1'b0}};
      acc_d   = 16'h0000;
    end else if (accept_s) begin
      if (!phase_q) begin
        hi_d    = in_data;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        case (state_q)
          S_HDR: begin
            if ((word_s == 16'h0000) || (word_s > 16'(MAX_WORDS))) begin
              state_d = S_ERR;
            end else begin
              len_d   = word_s[CW-1:0];
              cnt_d   = {CW{1'b0}};
              acc_d   = 16'h0000;
              state_d = S_LOAD;
            end
          end
          S_LOAD: begin
            we_d   = 1'b1;
            addr_d = cnt_q[AW-1:0];
            data_d = word_s;
            acc_d  = acc_q + word_s;
            cnt_d  = cnt_inc_s;
            if (cnt_inc_s == len_q) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_LOAD;
            end
          end
          S_CSUM: begin
            if (word_s == acc_q) begin
              state_d = S_RUN;
            end else begin
              state_d = S_ERR;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers; status outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HDR;
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      len_q   <= {CW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      acc_q   <= 16'h0000;
      we_q    <= 1'b0;
      addr_q  <= {AW{1'b0}};
      data_q  <= 16'h0000;
      ready_q <= 1'b1;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= (state_d == S_HDR) || (state_d == S_LOAD) || (state_d == S_CSUM);
      run_q   <= (state_d == S_RUN);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign in_ready = ready_q;
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_data  = data_q;
  assign core_run = run_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: happy path, bad checksum/length, max image,
// input gaps, mid-load reset and reload.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;
  logic        in_ready, im_we, core_run, load_err;
  logic [9:0]  im_addr;
  logic [15:0] im_data;

  imem_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .im_we(im_we), .im_addr(im_addr), .im_data(im_data),
    .core_run(core_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int dbl_we = 0;
  logic prev_we = 1'b0;
  logic [9:0]  wq_a[$];
  logic [15:0] wq_d[$];
  logic [9:0]  ea[$];
  logic [15:0] ed[$];
  logic [15:0] img[$];
  int gap_tab[10];
  int bidx = 0;

  // Write log, plus detection of strobes wider than one cycle
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wq_a.push_back(im_addr);
      wq_d.push_back(im_data);
      if (prev_we) dbl_we++;
    end
    prev_we = (im_we === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      repeat (gap_tab[bidx % 10]) @(negedge clk);
      bidx++;
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends every word of img except the last (the checksum, sent by the caller)
  task automatic send_img(input bit gaps);
    for (int i = 0; i < img.size() - 1; i++) begin
      send_byte(img[i][15:8], gaps);
      send_byte(img[i][7:0], gaps);
    end
  endtask

  task automatic clear_log();
    wq_a.delete(); wq_d.delete(); ea.delete(); ed.delete();
  endtask

  task automatic chk_writes(input string tag);
    int bad = 0;
    chk({tag, " write count"}, wq_a.size(), ea.size());
    for (int i = 0; i < wq_a.size() && i < ea.size(); i++)
      if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) bad++;
    chk({tag, " write contents"}, bad, 0);
  endtask

  task automatic pulse_reload(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    reload = 1'b1;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = b;
    end
    @(posedge clk);
    #1;
    reload   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic set_happy(input logic [15:0] csum);
    img = '{16'h0003, 16'h1234, 16'hABCD, 16'h0001, csum};
    clear_log();
    ea = '{10'd0, 10'd1, 10'd2};
    ed = '{16'h1234, 16'hABCD, 16'h0001};
  endtask

  initial begin
    gap_tab = '{0, 2, 1, 3, 0, 4, 1, 0, 2, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst im_we", im_we, 0);
    chk("rst im_addr", im_addr, 0);
    chk("rst im_data", im_data, 0);
    chk("rst core_run", core_run, 0);
    chk("rst load_err", load_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Happy path, continuous stream
    set_happy(16'hBE02);
    send_img(1'b0);
    send_byte(8'hBE, 1'b0);
    chk("happy run before last", core_run, 0);
    send_byte(8'h02, 1'b0);
    chk("happy core_run", core_run, 1);
    chk("happy in_ready", in_ready, 0);
    chk("happy load_err", load_err, 0);
    chk_writes("happy");
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    chk("run ignores bytes", core_run, 1);
    chk("run no writes", wq_a.size(), 3);

    // Bad checksum
    pulse_reload(1'b0, 8'h00);
    set_happy(16'hBE03);
    send_img(1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("badcs load_err", load_err, 1);
    chk("badcs core_run", core_run, 0);
    chk("badcs in_ready", in_ready, 0);
    chk_writes("badcs");

    // Bad length 0 and 1025
    pulse_reload(1'b0, 8'h00);
    chk("reload clears err", load_err, 0);
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len0 load_err", load_err, 1);
    chk("len0 in_ready", in_ready, 0);
    pulse_reload(1'b0, 8'h00);
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("len1025 load_err", load_err, 1);
    chk("len1025 core_run", core_run, 0);
    repeat (2) @(negedge clk);
    chk("badlen no writes", wq_a.size(), 0);

    // Happy image with in_valid gaps
    pulse_reload(1'b0, 8'h00);
    set_happy(16'hBE02);
    send_img(1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'h02, 1'b1);
    chk("gaps core_run", core_run, 1);
    chk_writes("gaps");

    // Reset after the first word, then a fresh load
    pulse_reload(1'b0, 8'h00);
    clear_log();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("w1 im_we", im_we, 1);
    chk("w1 im_addr", im_addr, 0);
    chk("w1 im_data", im_data, 16'h1234);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst im_we", im_we, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst core_run", core_run, 0);
    set_happy(16'hBE02);
    send_img(1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'h02, 1'b0);
    chk("midrst reload run", core_run, 1);
    chk_writes("midrst");

    // Reload in RUN with a byte alongside, then a partial header discarded by reload
    pulse_reload(1'b1, 8'h00);
    chk("reload core_run", core_run, 0);
    chk("reload load_err", load_err, 0);
    chk("reload in_ready", in_ready, 1);
    send_byte(8'h00, 1'b0);
    pulse_reload(1'b1, 8'h02);
    img = '{16'h0002, 16'h1111, 16'h2222, 16'h3333};
    clear_log();
    ea = '{10'd0, 10'd1};
    ed = '{16'h1111, 16'h2222};
    send_img(1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("img2 core_run", core_run, 1);
    chk_writes("img2");

    // Maximum image: 1024 x 0xFFFF, checksum 0xFC00
    pulse_reload(1'b0, 8'h00);
    clear_log();
    img.delete();
    img.push_back(16'h0400);
    for (int i = 0; i < 1024; i++) begin
      img.push_back(16'hFFFF);
      ea.push_back(10'(i));
      ed.push_back(16'hFFFF);
    end
    img.push_back(16'hFC00);
    send_img(1'b0);
    send_byte(8'hFC, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("max core_run", core_run, 1);
    chk("max load_err", load_err, 0);
    chk_writes("max");
    chk("max last addr", (wq_a.size() > 0) ? 32'(wq_a[wq_a.size()-1]) : 32'hFFFF, 1023);
    chk("we single cycle", dbl_we, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
